handshake_tx: RTL and testbench

- Downstream of the sender control FSM. Consumes its level requests `send_ready_ACK` and `send_game_lost`.
- Serializes them as framed handshake packets onto the GPIO handshake line to the opponent board.
- While a request is held, packets repeat back-to-back, separated by a fixed gap, so the opponent receiver can resynchronize at any time.
- The receiver-side decoder, a separate block, turns these packets into `game_start` / `game_end`.

---
 rtl/handshake_tx.sv | 139 +++++++++++++
 tb/tb_handshake_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/handshake_tx.sv
// Serializes sender-FSM level requests into framed handshake packets: sync preamble,
// type code, even parity, then an idle gap. Packets repeat for as long as a request is held.
module handshake_tx #(
  parameter int                 SYNC_W     = 8,
  parameter logic [SYNC_W-1:0]  SYNC_WORD  = 8'hA5,
  parameter int                 TYPE_W     = 4,
  parameter logic [TYPE_W-1:0]  ACK_CODE   = 4'b0111,
  parameter logic [TYPE_W-1:0]  END_CODE   = 4'b1100,
  parameter int                 GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_ready_ACK,
  input  logic       send_game_lost,
  output logic       hs_data,
  output logic       hs_valid,
  output logic       pkt_done,
  output logic       tx_busy,
  output logic [2:0] fsm_state
);

  localparam int MAX_A   = (SYNC_W > TYPE_W) ? SYNC_W : TYPE_W;
  localparam int MAX_N   = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
  localparam int CNT_W   = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int FRAME_W = SYNC_W + TYPE_W + 1;

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] TYPE_LAST = CNT_W'(TYPE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    TYPE   = 3'd2,
    PARITY = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [FRAME_W-1:0] frame, frame_nxt;
  logic               data_nxt, valid_nxt, done_nxt;
  logic               req;
  logic [TYPE_W-1:0]  sel_code;

  // The whole packet (sync, code, parity) is latched at packet start and shifted out
  // MSB first, so request changes mid-packet cannot disturb the bits in flight.
  assign req      = send_ready_ACK | send_game_lost;
  assign sel_code = send_game_lost ? END_CODE : ACK_CODE;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    frame_nxt = frame;
    data_nxt  = 1'b0;
    valid_nxt = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = SYNC;
          cnt_nxt   = '0;
          frame_nxt = {SYNC_WORD, sel_code, ^sel_code};
        end
      end
      SYNC: begin
        data_nxt  = frame[FRAME_W-1];
        valid_nxt = 1'b1;
        frame_nxt = {frame[FRAME_W-2:0], 1'b0};
        if (cnt == SYNC_LAST) begin
          state_nxt = TYPE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      TYPE: begin
        data_nxt  = frame[FRAME_W-1];
        valid_nxt = 1'b1;
        frame_nxt = {frame[FRAME_W-2:0], 1'b0};
        if (cnt == TYPE_LAST) begin
          state_nxt = PARITY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PARITY: begin
        data_nxt  = frame[FRAME_W-1];
        valid_nxt = 1'b1;
        done_nxt  = 1'b1;
        frame_nxt = {frame[FRAME_W-2:0], 1'b0};
        state_nxt = GAP;
        cnt_nxt   = '0;
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nxt = '0;
          if (req) begin
            state_nxt = SYNC;
            frame_nxt = {SYNC_WORD, sel_code, ^sel_code};
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the current state, so the line trails the FSM by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      frame    <= '0;
      hs_data  <= 1'b0;
      hs_valid <= 1'b0;
      pkt_done <= 1'b0;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      frame    <= frame_nxt;
      hs_data  <= data_nxt;
      hs_valid <= valid_nxt;
      pkt_done <= done_nxt;
      tx_busy  <= (state != IDLE);
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_handshake_tx.sv
// Bench for handshake_tx: fixed vector tables, hand-written corner sequences and a
// randomized run against a packet-level reference model.
module tb_handshake_tx;

  localparam int PERIOD = 17;

  logic       clk = 1'b0;
  logic       rst;
  logic       ack, lost;
  logic       hs_data, hs_valid, pkt_done, tx_busy;
  logic [2:0] fsm_state;
  logic       ack2, lost2;
  logic       d2, v2, p2, b2;
  logic [2:0] s2;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: whether a packet is running, position within it, latched code.
  bit         m_act;
  int         m_pos;
  logic [3:0] m_code;

  logic [3:0] obs [0:255];
  int         cyc;

  typedef struct {
    bit         alt;
    logic       a;
    logic       l;
    logic [3:0] want;
  } vec_t;
  vec_t vecs [$];

  always #5 clk = ~clk;

  handshake_tx dut (
    .clk(clk), .rst(rst), .send_ready_ACK(ack), .send_game_lost(lost),
    .hs_data(hs_data), .hs_valid(hs_valid), .pkt_done(pkt_done), .tx_busy(tx_busy),
    .fsm_state(fsm_state)
  );

  handshake_tx #(.SYNC_WORD(8'hFF), .GAP_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .send_ready_ACK(ack2), .send_game_lost(lost2),
    .hs_data(d2), .hs_valid(v2), .pkt_done(p2), .tx_busy(b2), .fsm_state(s2)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] want);
    n_vec++;
    if (act !== want) begin
      n_mis++;
      $display("FAIL %s: got d/v/p/b=%b, expected %b", name, act, want);
    end
  endtask

  task automatic check_val(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  // Expected {hs_data, hs_valid, pkt_done, tx_busy} for a given packet position.
  function automatic logic [3:0] model_out(bit act, int pos, logic [3:0] code);
    logic [7:0] sw;
    logic [3:0] c;
    sw = 8'hA5;
    c  = code;
    if (!act) return 4'b0000;
    if (pos < 8) begin
      sw = sw << pos;
      return {sw[7], 3'b101};
    end
    if (pos < 12) begin
      c = c << (pos - 8);
      return {c[3], 3'b101};
    end
    if (pos == 12) return {^code, 3'b111};
    return 4'b0001;
  endfunction

  task automatic model_edge(input logic a, input logic l);
    logic [3:0] sel;
    sel = l ? 4'b1100 : 4'b0111;
    if (!m_act) begin
      if (a | l) begin
        m_act  = 1'b1;
        m_pos  = 0;
        m_code = sel;
      end
    end else if (m_pos == PERIOD - 1) begin
      if (a | l) begin
        m_pos  = 0;
        m_code = sel;
      end else begin
        m_act = 1'b0;
      end
    end else begin
      m_pos++;
    end
  endtask

  task automatic do_reset();
    ack = 1'b0; lost = 1'b0; ack2 = 1'b0; lost2 = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_act = 1'b0; m_pos = 0; m_code = 4'b0000;
    cyc = 0;
  endtask

  // Called at a falling edge: drive inputs, advance one clock, compare with the model.
  task automatic step(input logic a, input logic l, input string tag);
    logic [3:0] want;
    ack  = a;
    lost = l;
    want = model_out(m_act, m_pos, m_code);
    model_edge(a, l);
    @(posedge clk);
    @(negedge clk);
    if (cyc < 256) obs[cyc] = {hs_data, hs_valid, pkt_done, tx_busy};
    check($sformatf("%s_c%0d", tag, cyc), {hs_data, hs_valid, pkt_done, tx_busy}, want);
    cyc++;
  endtask

  function automatic int type_bits(input int s);
    return {28'd0, obs[s][3], obs[s+1][3], obs[s+2][3], obs[s+3][3]};
  endfunction

  initial begin
    logic [0:18] t_d, t_v, t_p, t_b;
    logic [0:15] u_d, u_v, u_p, u_b;
    vec_t v;
    int   cnt;
    logic ra, rl;

    t_d = 19'b0_10100101_0111_1_0000_1;
    t_v = 19'b0_11111111_1111_1_0000_1;
    t_p = 19'b0_00000000_0000_1_0000_0;
    t_b = 19'b0_11111111_1111_1_1111_1;
    for (int k = 0; k < 19; k++) begin
      v.alt = 1'b0; v.a = 1'b1; v.l = 1'b0;
      v.want = {t_d[k], t_v[k], t_p[k], t_b[k]};
      vecs.push_back(v);
    end
    u_d = 16'b0_11111111_0111_1_0_1;
    u_v = 16'b0_11111111_1111_1_0_1;
    u_p = 16'b0_00000000_0000_1_0_0;
    u_b = 16'b0_11111111_1111_1_1_1;
    for (int k = 0; k < 16; k++) begin
      v.alt = 1'b1; v.a = 1'b1; v.l = 1'b0;
      v.want = {u_d[k], u_v[k], u_p[k], u_b[k]};
      vecs.push_back(v);
    end

    do_reset();
    check("reset_state", {hs_data, hs_valid, pkt_done, tx_busy}, 4'b0000);

    // Table-driven: ACK held on the default block, then on the GAP=1 / sync 0xFF block.
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0 && vecs[i].alt != vecs[i-1].alt) do_reset();
      if (vecs[i].alt) begin
        ack2 = vecs[i].a; lost2 = vecs[i].l;
      end else begin
        ack = vecs[i].a; lost = vecs[i].l;
      end
      @(posedge clk);
      @(negedge clk);
      if (vecs[i].alt)
        check($sformatf("param_c%0d", i - 19), {d2, v2, p2, b2}, vecs[i].want);
      else
        check($sformatf("ack_held_c%0d", i), {hs_data, hs_valid, pkt_done, tx_busy}, vecs[i].want);
    end

    // Both requests held: END wins, repeats every 17 cycles.
    do_reset();
    for (int k = 0; k < 32; k++) step(1'b1, 1'b1, "both");
    check_val("both_type1", type_bits(9), 4'b1100);
    check_val("both_par1", {obs[13][3], obs[13][1]}, 2'b01);
    check_val("both_type2", type_bits(26), 4'b1100);
    check_val("both_sync2_start", {obs[17][2], obs[18][3], obs[18][2]}, 3'b011);

    // Single-cycle ACK pulse: exactly one packet, busy cycles 1..17.
    do_reset();
    step(1'b1, 1'b0, "pulse");
    for (int k = 0; k < 22; k++) step(1'b0, 1'b0, "pulse");
    cnt = 0;
    for (int k = 1; k <= 17; k++) cnt += int'(obs[k][0]);
    check_val("pulse_busy_span", cnt, 17);
    check_val("pulse_busy_end", int'(obs[18][0]), 0);
    cnt = 0;
    for (int k = 0; k < 23; k++) cnt += int'(obs[k][2]);
    check_val("pulse_valid_cycles", cnt, 13);

    // ACK switched to game-lost at cycle 5.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, "switch");
    for (int k = 5; k < 32; k++) step(1'b0, 1'b1, "switch");
    check_val("switch_type1", type_bits(9), 4'b0111);
    check_val("switch_type2", type_bits(26), 4'b1100);

    // Asynchronous reset in the middle of the type field.
    do_reset();
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, "rst_mid");
    rst = 1'b1;
    #1;
    check("async_rst_outputs", {hs_data, hs_valid, pkt_done, tx_busy}, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_act = 1'b0; m_pos = 0; cyc = 0;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, "after_rst");
    check("after_rst_first_sync", obs[1], 4'b1101);

    // Randomized request levels against the model.
    do_reset();
    ra = 1'b0; rl = 1'b0;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        ra = 1'($urandom_range(0, 1));
        rl = ($urandom_range(0, 3) == 0);
      end
      step(ra, rl, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
